// File: rtl/run_monitor.sv
// Run monitor: starts a CPU run, halts it on a breakpoint or timeout, then streams the register file.
// Define RUN_MONITOR_DUMP_EN to build the register dump path; otherwise a halted run goes straight to DONE.
module run_monitor #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_BP   = 4,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PC_W-1:0]        pc_i,
    input  logic                   pc_valid,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [CNT_W-1:0]       timeout_limit,
    output logic                   cpu_halt,
    output logic [4:0]             reg_sel,
    input  logic [DATA_W-1:0]      reg_data,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [4:0]             dump_idx,
    output logic [DATA_W-1:0]      dump_data,
    output logic [1:0]             status,
    output logic [2:0]             hit_idx,
    output logic [CNT_W-1:0]       cycle_count,
    output logic                   done
);

    localparam logic [1:0] StatusNone    = 2'd0;
    localparam logic [1:0] StatusBreak   = 2'd1;
    localparam logic [1:0] StatusTimeout = 2'd2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
`ifdef RUN_MONITOR_DUMP_EN
        StLoad    = 3'd2,
        StPresent = 3'd3,
`endif
        StDone    = 3'd4
    } state_e;

`ifdef RUN_MONITOR_DUMP_EN
    localparam state_e     RunExit = StLoad;
    localparam logic [4:0] LastIdx = 5'(NUM_REGS - 1);
`else
    localparam state_e     RunExit = StDone;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       status_q, status_d;
    logic [2:0]       hit_q, hit_d;
`ifdef RUN_MONITOR_DUMP_EN
    logic [4:0]       idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
`endif

    logic             bp_hit;
    logic [2:0]       bp_sel;
    logic [CNT_W:0]   cnt_plus;
    logic             timeout_hit;

    // Lowest enabled matching channel wins.
    always_comb begin
        bp_hit = 1'b0;
        bp_sel = 3'd0;
        for (int i = 0; i < int'(NUM_BP); i++) begin
            if (!bp_hit && pc_valid && bp_en[i] && (pc_i == bp_addr[i*PC_W +: PC_W])) begin
                bp_hit = 1'b1;
                bp_sel = 3'(i);
            end
        end
    end

    // Extra bit keeps a saturated counter from wrapping into a false match.
    assign cnt_plus    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_hit = (timeout_limit != '0) && (cnt_plus == {1'b0, timeout_limit});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        hit_d    = hit_q;
`ifdef RUN_MONITOR_DUMP_EN
        idx_d    = idx_q;
        data_d   = data_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StRun;
                    cnt_d    = '0;
                    status_d = StatusNone;
                    hit_d    = 3'd0;
`ifdef RUN_MONITOR_DUMP_EN
                    idx_d    = 5'd0;
`endif
                end
            end
            StRun: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_plus[CNT_W-1:0];
                if (bp_hit) begin
                    status_d = StatusBreak;
                    hit_d    = bp_sel;
                    state_d  = RunExit;
                end else if (timeout_hit) begin
                    status_d = StatusTimeout;
                    state_d  = RunExit;
                end
            end
`ifdef RUN_MONITOR_DUMP_EN
            StLoad: begin
                data_d  = reg_data;
                state_d = StPresent;
            end
            StPresent: begin
                if (dump_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StLoad;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            status_q <= StatusNone;
            hit_q    <= 3'd0;
`ifdef RUN_MONITOR_DUMP_EN
            idx_q    <= 5'd0;
            data_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            hit_q    <= hit_d;
`ifdef RUN_MONITOR_DUMP_EN
            idx_q    <= idx_d;
            data_q   <= data_d;
`endif
        end
    end

    assign cpu_halt    = (state_q != StRun);
    assign done        = (state_q == StDone);
    assign status      = status_q;
    assign hit_idx     = hit_q;
    assign cycle_count = cnt_q;

`ifdef RUN_MONITOR_DUMP_EN
    assign dump_valid = (state_q == StPresent);
    assign reg_sel    = ((state_q == StLoad) || (state_q == StPresent)) ? idx_q : 5'd0;
    assign dump_idx   = idx_q;
    assign dump_data  = data_q;
`else
    logic unused_dump;
    assign unused_dump = ^{dump_ready, reg_data};
    assign dump_valid  = 1'b0;
    assign reg_sel     = 5'd0;
    assign dump_idx    = 5'd0;
    assign dump_data   = '0;
`endif

endmodule
